// File: rtl/lcd_refresh_sequencer_pkg.sv
// Shared constants, state encoding and byte-selection helpers for the LCD
// refresh sequencer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] CH_H       = 8'h48;
  localparam logic [7:0] CH_J       = 8'h4A;
  localparam logic [7:0] CH_E       = 8'h45;
  localparam logic [7:0] CH_F       = 8'h46;
  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_ZERO    = 8'h30;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  localparam logic [3:0] INIT_LAST  = 4'd3;
  localparam logic [3:0] FRAME_LAST = 4'd11;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_SNAP,
    ST_REFRESH,
    ST_IDLE
  } seq_state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  // Cycles for a duration in microseconds, never less than one.
  function automatic int unsigned us_to_cycles(input longint unsigned clk_freq,
                                               input longint unsigned us);
    longint unsigned c;
    c = clk_freq * us / 64'd1_000_000;
    if (c == 64'd0) c = 64'd1;
    return 32'(c);
  endfunction

  function automatic logic [7:0] digit(input logic [7:0] v);
    return (v <= 8'd9) ? CH_ZERO + v : CH_UNKNOWN;
  endfunction

  function automatic lcd_word_t init_word(input logic [3:0] idx);
    lcd_word_t w;
    w.rs = 1'b0;
    case (idx)
      4'd0:    w.data = CMD_FUNC_SET;
      4'd1:    w.data = CMD_DISP_ON;
      4'd2:    w.data = CMD_CLEAR;
      default: w.data = CMD_ENTRY;
    endcase
    return w;
  endfunction

  function automatic lcd_word_t frame_word(input logic [3:0] idx,
                                           input logic [7:0] hunger,
                                           input logic [7:0] joy,
                                           input logic [7:0] energy,
                                           input logic [7:0] face);
    lcd_word_t w;
    w.rs = 1'b1;
    case (idx)
      4'd0:    begin w.rs = 1'b0; w.data = CMD_LINE1; end
      4'd1:    w.data = CH_H;
      4'd2:    w.data = digit(hunger);
      4'd3:    w.data = CH_SPACE;
      4'd4:    w.data = CH_J;
      4'd5:    w.data = digit(joy);
      4'd6:    w.data = CH_SPACE;
      4'd7:    w.data = CH_E;
      4'd8:    w.data = digit(energy);
      4'd9:    begin w.rs = 1'b0; w.data = CMD_LINE2; end
      4'd10:   w.data = CH_F;
      default: w.data = digit(face);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lcd_refresh_sequencer_if.sv
// HD44780 8-bit parallel write bus.
interface lcd_refresh_sequencer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_refresh_sequencer_phy.sv
// Single LCD write: SETUP (1 cycle), PULSE (T_EN cycles), WAIT (short/long).
// A start offered on the last WAIT cycle chains straight into the next SETUP.
module lcd_write_phy
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           rs,
  input  logic [7:0]                     data,
  input  logic                           long_wait,
  output logic                           done,
  lcd_refresh_sequencer_if.master        lcd
);

  localparam logic [31:0] T_EN    = us_to_cycles(64'(CLK_FREQ), 64'd1);
  localparam logic [31:0] T_SHORT = us_to_cycles(64'(CLK_FREQ), 64'd50);
  localparam logic [31:0] T_LONG  = us_to_cycles(64'(CLK_FREQ), 64'd2000);

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  phase_t      phase;
  logic [31:0] cnt;
  logic        long_q;

  assign done       = (phase == PH_WAIT) && (cnt == 32'd0);
  assign lcd.lcd_rw = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PH_IDLE;
      cnt          <= '0;
      long_q       <= 1'b0;
      lcd.lcd_e    <= 1'b0;
      lcd.lcd_rs   <= 1'b0;
      lcd.lcd_data <= 8'h00;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            lcd.lcd_rs   <= rs;
            lcd.lcd_data <= data;
            long_q       <= long_wait;
            phase        <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          lcd.lcd_e <= 1'b1;
          cnt       <= T_EN - 32'd1;
          phase     <= PH_PULSE;
        end
        PH_PULSE: begin
          if (cnt == 32'd0) begin
            lcd.lcd_e <= 1'b0;
            cnt       <= (long_q ? T_LONG : T_SHORT) - 32'd1;
            phase     <= PH_WAIT;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        PH_WAIT: begin
          if (cnt == 32'd0) begin
            if (start) begin
              lcd.lcd_rs   <= rs;
              lcd.lcd_data <= data;
              long_q       <= long_wait;
              phase        <= PH_SETUP;
            end else begin
              phase <= PH_IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_sequencer.sv
// Power-up/init then redraws both LCD lines from a snapshot of the pet state
// whenever an update is requested; requests while busy collapse into one.
module lcd_refresh_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ             = 50_000_000,
  parameter int unsigned MAX_VALUE_STATISTICS = 5,
  parameter int unsigned NUM_FACES            = 9
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [$clog2(NUM_FACES)-1:0]            face,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Hunger,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Joy,
  input  logic [$clog2(MAX_VALUE_STATISTICS)-1:0] Energy,
  input  logic                                    new_update,
  output logic                                    busy,
  lcd_refresh_sequencer_if.master                 lcd
);

  localparam int unsigned FACE_W = $clog2(NUM_FACES);
  localparam int unsigned STAT_W = $clog2(MAX_VALUE_STATISTICS);
  localparam logic [31:0] T_PWR  = us_to_cycles(64'(CLK_FREQ), 64'd20000);

  seq_state_t        state;
  logic [31:0]       pwr_cnt;
  logic [3:0]        idx;
  logic              pending;
  logic [FACE_W-1:0] snap_face;
  logic [STAT_W-1:0] snap_hunger;
  logic [STAT_W-1:0] snap_joy;
  logic [STAT_W-1:0] snap_energy;

  logic      issue;
  lcd_word_t word;
  logic      long_wait;
  logic      done;

  // The next write is offered while the previous one finishes its WAIT, so
  // consecutive writes run back to back without an idle cycle.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    issue = 1'b0;
    word  = '0;
    case (state)
      ST_POWERUP: if (pwr_cnt == 32'd0) begin
        issue = 1'b1;
        word  = init_word(4'd0);
      end
      ST_INIT: if (done && idx != INIT_LAST) begin
        issue = 1'b1;
        word  = init_word(idx + 4'd1);
      end
      ST_SNAP: begin
        issue = 1'b1;
        word  = frame_word(4'd0, 8'(snap_hunger), 8'(snap_joy),
                           8'(snap_energy), 8'(snap_face));
      end
      ST_REFRESH: if (done && idx != FRAME_LAST) begin
        issue = 1'b1;
        word  = frame_word(idx + 4'd1, 8'(snap_hunger), 8'(snap_joy),
                           8'(snap_energy), 8'(snap_face));
      end
      default: ;
    endcase
  end

  assign long_wait = !word.rs && (word.data == CMD_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_POWERUP;
      pwr_cnt     <= T_PWR - 32'd1;
      idx         <= '0;
      busy        <= 1'b1;
      pending     <= 1'b0;
      snap_face   <= '0;
      snap_hunger <= '0;
      snap_joy    <= '0;
      snap_energy <= '0;
    end else begin
      if (new_update) pending <= 1'b1;
      case (state)
        ST_POWERUP: begin
          if (pwr_cnt == 32'd0) begin
            state <= ST_INIT;
            idx   <= '0;
          end else begin
            pwr_cnt <= pwr_cnt - 32'd1;
          end
        end
        ST_INIT: begin
          if (done) begin
            if (idx == INIT_LAST) state <= ST_SNAP;
            else                  idx   <= idx + 4'd1;
          end
        end
        ST_SNAP: begin
          snap_face   <= face;
          snap_hunger <= Hunger;
          snap_joy    <= Joy;
          snap_energy <= Energy;
          // A request landing on the snapshot cycle still earns a redraw.
          pending     <= new_update;
          idx         <= '0;
          state       <= ST_REFRESH;
        end
        ST_REFRESH: begin
          if (done) begin
            if (idx == FRAME_LAST) begin
              if (pending || new_update) begin
                state <= ST_SNAP;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_IDLE: begin
          if (pending || new_update) begin
            state <= ST_SNAP;
            busy  <= 1'b1;
          end
        end
        default: state <= ST_POWERUP;
      endcase
    end
  end

  lcd_write_phy #(.CLK_FREQ(CLK_FREQ)) u_phy (
    .clk       (clk),
    .rst_n     (reset),
    .start     (issue),
    .rs        (word.rs),
    .data      (word.data),
    .long_wait (long_wait),
    .done      (done),
    .lcd       (lcd)
  );

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Directed bench for the LCD refresh sequencer at CLK_FREQ = 1 MHz.
module tb_lcd_refresh_sequencer;

  localparam logic [7:0] INIT_EXP  [4]  = '{8'h38, 8'h0C, 8'h01, 8'h06};
  localparam logic [7:0] FRAME_EXP [12] = '{8'h80, 8'h48, 8'h33, 8'h20, 8'h4A, 8'h31,
                                           8'h20, 8'h45, 8'h34, 8'hC0, 8'h46, 8'h37};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] face = 4'd7;
  logic [2:0] hunger = 3'd3;
  logic [2:0] joy = 3'd1;
  logic [2:0] energy = 3'd4;
  logic       new_update = 1'b0;
  logic       busy;

  lcd_refresh_sequencer_if lcd_bus ();

  lcd_refresh_sequencer #(
    .CLK_FREQ             (1_000_000),
    .MAX_VALUE_STATISTICS (5),
    .NUM_FACES            (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .face       (face),
    .Hunger     (hunger),
    .Joy        (joy),
    .Energy     (energy),
    .new_update (new_update),
    .busy       (busy),
    .lcd        (lcd_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every rising lcd_e is logged with its bus value and cycle number.
  logic [8:0] strobes[$];
  int         strobe_cyc[$];
  logic       e_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (lcd_bus.lcd_e && !e_prev) begin
      strobes.push_back({lcd_bus.lcd_rs, lcd_bus.lcd_data});
      strobe_cyc.push_back(cyc);
    end
    e_prev = lcd_bus.lcd_e;
  end

  task automatic wait_strobes(input int n, input int budget, input string what);
    int k = 0;
    while (strobes.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (strobes.size() < n) begin
      total++; bad++;
      $display("FAIL %s timeout: strobes=%0d required=%0d", what, strobes.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string what, output int at);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    at = cyc;
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL %s timeout: busy=%b required=0", what, busy);
    end
  endtask

  task automatic pulse_update(output int at);
    @(negedge clk);
    new_update = 1'b1;
    at = cyc;
    @(negedge clk);
    new_update = 1'b0;
  endtask

  int r0;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (lcd_bus.lcd_e !== 1'b0) begin bad++; $display("FAIL reset_e got=%b exp=0", lcd_bus.lcd_e); end
    total++; if (lcd_bus.lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs got=%b exp=0", lcd_bus.lcd_rs); end
    total++; if (lcd_bus.lcd_rw !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b exp=0", lcd_bus.lcd_rw); end
    total++; if (lcd_bus.lcd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", lcd_bus.lcd_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    reset = 1'b1;
    r0 = cyc;
  endtask

  task automatic test_powerup_init();
    wait_strobes(4, 25000, "powerup_init");
    total++;
    if (strobe_cyc[0] < r0 + 20000) begin
      bad++; $display("FAIL powerup_wait first_e_cycle=%0d min=%0d", strobe_cyc[0], r0 + 20000);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (strobes[i] !== {1'b0, INIT_EXP[i]}) begin
        bad++; $display("FAIL init_cmd%0d got=%h exp=%h", i, strobes[i], {1'b0, INIT_EXP[i]});
      end
    end
    total++;
    if (strobe_cyc[3] - strobe_cyc[2] < 2000) begin
      bad++; $display("FAIL clear_gap got=%0d min=2000", strobe_cyc[3] - strobe_cyc[2]);
    end
  endtask

  task automatic test_first_frame();
    int t_idle;
    wait_strobes(16, 5000, "first_frame");
    for (int i = 0; i < 12; i++) begin
      total++;
      if (strobes[4+i] !== {(i != 0 && i != 9), FRAME_EXP[i]}) begin
        bad++; $display("FAIL frame_byte%0d got=%h exp=%h", i, strobes[4+i],
                        {(i != 0 && i != 9), FRAME_EXP[i]});
      end
    end
    wait_idle(500, "first_frame_idle", t_idle);
    // Last strobe, then PULSE end + 50-cycle WAIT + transition edge.
    total++;
    if (t_idle - strobe_cyc[15] !== 51) begin
      bad++; $display("FAIL busy_fall got=%0d exp=51", t_idle - strobe_cyc[15]);
    end
  endtask

  task automatic test_latency();
    int t_pulse, t_idle, base;
    @(negedge clk);
    hunger = 3'd0;
    base = strobes.size();
    pulse_update(t_pulse);
    wait_strobes(base + 12, 2000, "latency_frame");
    total++;
    if (strobe_cyc[base] !== t_pulse + 3) begin
      bad++; $display("FAIL latency got=%0d exp=%0d", strobe_cyc[base] - t_pulse, 3);
    end
    total++;
    if (strobes[base+2] !== 9'h130) begin
      bad++; $display("FAIL hunger_digit got=%h exp=130", strobes[base+2]);
    end
    total++;
    if (strobes[base+5] !== 9'h131) begin
      bad++; $display("FAIL joy_digit got=%h exp=131", strobes[base+5]);
    end
    wait_idle(500, "latency_idle", t_idle);
  endtask

  task automatic test_back_to_back();
    int t, base;
    base = strobes.size();
    pulse_update(t);
    wait_strobes(base + 3, 1000, "b2b_a");
    joy = 3'd2;
    pulse_update(t);
    wait_strobes(base + 6, 1000, "b2b_b");
    pulse_update(t);
    wait_strobes(base + 10, 1000, "b2b_c");
    pulse_update(t);
    wait_idle(3000, "b2b_idle", t);
    repeat (300) @(negedge clk);
    total++;
    if (strobes.size() !== base + 24) begin
      bad++; $display("FAIL b2b_count got=%0d exp=%0d", strobes.size() - base, 24);
    end
    total++;
    if (strobes[base+5] !== 9'h131) begin
      bad++; $display("FAIL b2b_old_joy got=%h exp=131", strobes[base+5]);
    end
    total++;
    if (strobes[base+12] !== 9'h080) begin
      bad++; $display("FAIL b2b_second_start got=%h exp=080", strobes[base+12]);
    end
    total++;
    if (strobes[base+17] !== 9'h132) begin
      bad++; $display("FAIL b2b_new_joy got=%h exp=132", strobes[base+17]);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_face_unknown();
    int t, base;
    @(negedge clk);
    face = 4'd12;
    base = strobes.size();
    pulse_update(t);
    wait_strobes(base + 12, 2000, "face_frame");
    total++;
    if (strobes[base+10] !== 9'h146) begin
      bad++; $display("FAIL face_label got=%h exp=146", strobes[base+10]);
    end
    total++;
    if (strobes[base+11] !== 9'h13F) begin
      bad++; $display("FAIL face_unknown got=%h exp=13F", strobes[base+11]);
    end
    wait_idle(500, "face_idle", t);
  endtask

  task automatic test_reset_midwrite();
    int t, base, n0, r;
    base = strobes.size();
    pulse_update(t);
    wait_strobes(base + 6, 2000, "midwrite_reach");
    total++;
    if (lcd_bus.lcd_e !== 1'b1) begin
      bad++; $display("FAIL midwrite_pulse got=%b exp=1", lcd_bus.lcd_e);
    end
    reset = 1'b0;
    #1;
    total++;
    if (lcd_bus.lcd_e !== 1'b0) begin
      bad++; $display("FAIL midwrite_e_drop got=%b exp=0", lcd_bus.lcd_e);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midwrite_busy got=%b exp=1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    n0 = strobes.size();
    wait_strobes(n0 + 4, 25000, "rerun_init");
    total++;
    if (strobe_cyc[n0] < r + 20000) begin
      bad++; $display("FAIL rerun_powerup first_e_cycle=%0d min=%0d", strobe_cyc[n0], r + 20000);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (strobes[n0+i] !== {1'b0, INIT_EXP[i]}) begin
        bad++; $display("FAIL rerun_cmd%0d got=%h exp=%h", i, strobes[n0+i], {1'b0, INIT_EXP[i]});
      end
    end
    wait_idle(5000, "rerun_idle", t);
  endtask

  initial begin
    test_reset();
    test_powerup_init();
    test_first_frame();
    test_latency();
    test_back_to_back();
    test_face_unknown();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_refresh_sequencer.md
Name: lcd_refresh_sequencer

Overview:
Consumer end of the status-change path. It takes the `new_update` pulse/level from the change-detection block, snapshots face and the three statistics, and drives an HD44780-compatible 16x2 LCD over an 8-bit parallel bus. It first runs the power-up and initialisation sequence, then redraws both display lines whenever an update is requested. It sits between the pet-state logic and the LCD pins.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz; all timing counts derive from it
MAX_VALUE_STATISTICS, 5, statistic range; statistic input width is clog2 of this
NUM_FACES, 9, face range; face input width is clog2 of this

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
face  in  clog2(NUM_FACES)  current face index
Hunger  in  clog2(MAX_VALUE_STATISTICS)  hunger statistic
Joy  in  clog2(MAX_VALUE_STATISTICS)  joy statistic
Energy  in  clog2(MAX_VALUE_STATISTICS)  energy statistic
new_update  in  1  refresh request, sampled every cycle; level or pulse accepted
busy  out  1  high whenever the FSM is not in IDLE
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  LCD enable strobe
lcd_data  out  8  LCD data bus

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on port `reset`.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=1, pending=0, snapshot=0.
- Timing counts:
  - T_EN = CLK_FREQ/1_000_000 cycles (1 us), minimum 1.
  - T_SHORT = 50 us.
  - T_LONG = 2 ms.
  - T_PWR = 20 ms.
- One LCD write is three phases: SETUP (1 cycle), PULSE (T_EN cycles), WAIT.
  - SETUP: lcd_rs and lcd_data become valid; lcd_e=0.
  - PULSE: lcd_e=1.
  - WAIT: lcd_e=0. Duration is T_LONG after the clear command (8'h01) and T_SHORT after every other write.
  - lcd_rs and lcd_data hold their values from SETUP through the end of WAIT.
- Top FSM states: POWERUP, INIT, SNAP, REFRESH, IDLE.
- POWERUP: wait T_PWR cycles, then go to INIT.
- INIT: issue 4 commands in order: 8'h38, 8'h0C, 8'h01, 8'h06. Then go to SNAP. The first refresh always follows init.
- SNAP: 1 cycle.
  - Register face, Hunger, Joy, Energy into the snapshot.
  - Clear pending.
  - Go to REFRESH.
- REFRESH: 12 writes, index 0..11, all taken from the snapshot.
  - Write 0: cmd 8'h80.
  - Writes 1..8: data 'H', d(Hunger), ' ', 'J', d(Joy), ' ', 'E', d(Energy).
  - Write 9: cmd 8'hC0.
  - Writes 10..11: data 'F', d(face).
- Digit map: d(v) = 8'h30+v for v<=9. For v>=10, d(v) = 8'h3F ('?').
- IDLE: busy=0. On pending=1 or new_update=1, go to SNAP the next cycle.
- Requests arriving while not in IDLE (POWERUP/INIT/SNAP/REFRESH):
  - new_update=1 sets pending.
  - Multiple requests collapse into one follow-up refresh.
  - After write 11's WAIT completes, the FSM goes to SNAP if pending=1, else to IDLE.
- new_update=1 in the same cycle as SNAP: the request is not cleared by SNAP; it sets pending, which forces one more refresh.
- Inputs changing during REFRESH do not affect the current frame; only the snapshot is displayed.
- Reset mid-write: lcd_e drops immediately, and the full POWERUP and INIT sequence reruns.
- Latency: new_update accepted in IDLE leads to the first lcd_e rise 3 cycles later (SNAP, SETUP, PULSE start).

Decomposition:
- Package lcd_pkg:
  - command constants CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01, CMD_ENTRY=8'h06, CMD_LINE1=8'h80, CMD_LINE2=8'hC0.
  - ASCII constants for 'H', 'J', 'E', 'F', ' ', '0', '?'.
  - Timing-count function of CLK_FREQ.
  - Top FSM state encoding.
- Sub-module lcd_write_phy:
  - Inputs: start, rs, data, long_wait.
  - Outputs: done (1-cycle pulse at the end of WAIT) and the LCD pins.
  - Owns the SETUP/PULSE/WAIT counter.
- The top level holds the sequence FSM, write index, snapshot and pending flag.

Test Plan:
1. All benches use CLK_FREQ=1_000_000, so T_EN=1, T_SHORT=50, T_LONG=2000, T_PWR=20000.
2. Reset, then release -> no lcd_e pulse for 20000 cycles; then 4 command strobes with data 38,0C,01,06 and rs=0; the gap after 01 is >=2000 cycles.
3. Hunger=3, Joy=1, Energy=4, face=7 held from reset -> first frame bytes 80,48,33,20,4A,31,20,45,34,C0,46,37; rs=1 except on 80 and C0; busy falls after the last WAIT.
4. In IDLE, change Hunger to 0 and pulse new_update for 1 cycle -> lcd_e rises on cycle 3 after the pulse; the frame shows 30 at write 2.
5. Three new_update pulses during one REFRESH, with Joy changed to 2 mid-frame -> the current frame still shows the old Joy; exactly one extra frame follows, showing 32; then IDLE.
6. face=12 (>=10) -> the last byte is 3F.
7. Assert reset during the PULSE of write 5 -> lcd_e=0 asynchronously; after release the POWERUP wait (20000 cycles) and INIT repeat in full.
